// File: rtl/svfloat_pkg.sv
// Shared float types, the converter FSM state encoding and a format helper
// for the svfloat family of blocks.
package svfloat;

  typedef logic [15:0] float16;
  typedef logic [31:0] float32;
  typedef logic [63:0] float64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } itof_state_e;

  // Exponent field width of an IEEE-style binary format, by total width.
  function automatic int exp_bits(input int total);
    case (total)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/svfloat_packer.sv
// Assembles sign, unbiased exponent and fraction into an IEEE-style float,
// with forced zero / infinity encodings for out-of-range results.
module svfloat_packer #(
  parameter int N = 32,
  parameter int E = 8
) (
  input  logic                i_sign,
  input  logic signed [31:0]  i_exp,
  input  logic [N-E-2:0]      i_mant,
  input  logic                i_is_zero,
  input  logic                i_is_inf,
  output logic [N-1:0]        o_float
);

  localparam int BIAS = (1 << (E - 1)) - 1;

  logic [E-1:0] w_bexp;

  assign w_bexp = E'(i_exp + BIAS);

  // Choose infinity, zero or a normal encoding.
  always_comb begin
    o_float = {i_sign, w_bexp, i_mant};
    if (i_is_inf) begin
      o_float = {i_sign, {E{1'b1}}, {(N-E-1){1'b0}}};
    end else if (i_is_zero) begin
      o_float = {i_sign, {(N-1){1'b0}}};
    end else begin
      o_float = {i_sign, w_bexp, i_mant};
    end
  end

endmodule

// File: rtl/svfloat_itof.sv
// Sequential fixed-point to float converter. The magnitude is normalised one
// bit per cycle, then rounded and packed. Build macro SVFLOAT_ITOF_ROUND_EN
// selects round-to-nearest-even; without it the result truncates toward zero.
module svfloat_itof
  import svfloat::*;
#(
  parameter type float = svfloat::float32,
  parameter int  width = 32,
  parameter int  frac  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [width-1:0]        in,
  input  logic                    issigned,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$bits(float)-1:0] out,
  output logic                    inexact
);

  localparam int N    = $bits(float);
  localparam int E    = exp_bits(N);
  localparam int M    = N - 1 - E;
  localparam int XW   = width + M + 2;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EMAX = BIAS;
  localparam int EMIN = 1 - BIAS;
  localparam logic signed [31:0] EXP0 = 32'(width - 1 - frac);

  itof_state_e        r_state;
  itof_state_e        w_next;
  logic [width-1:0]   r_mag;
  logic               r_sign;
  logic signed [31:0] r_exp;
  logic [N-1:0]       r_out;
  logic               r_inexact;

  logic               w_neg;
  logic [width-1:0]   w_mag_in;
  logic [XW-1:0]      w_ext;
  logic [M:0]         w_kept;
  logic               w_guard;
  logic               w_sticky;
  logic               w_round_up;
  logic [M+1:0]       w_sum;
  logic               w_carry;
  logic [M-1:0]       w_mant;
  logic signed [31:0] w_exp_fin;
  logic               w_is_inf;
  logic               w_is_zero;
  logic               w_inexact_fin;
  logic [N-1:0]       w_packed;

  // Signed minimum negates onto itself, which is the correct unsigned magnitude.
  assign w_neg    = issigned & in[width-1];
  assign w_mag_in = w_neg ? (~in + {{(width-1){1'b0}}, 1'b1}) : in;

  // Zero-pad below the magnitude so guard/sticky exist for any width.
  assign w_ext    = {r_mag, {(M+2){1'b0}}};
  assign w_kept   = w_ext[XW-1 -: M+1];
  assign w_guard  = w_ext[XW-M-2];
  assign w_sticky = |w_ext[XW-M-3:0];

`ifdef SVFLOAT_ITOF_ROUND_EN
  assign w_round_up = w_guard & (w_sticky | w_kept[0]);
`else
  assign w_round_up = 1'b0;
`endif

  assign w_sum     = {1'b0, w_kept} + {{(M+1){1'b0}}, w_round_up};
  assign w_carry   = w_sum[M+1];
  // On carry the sum is exactly 2.0, so the shifted fraction is all zeros.
  assign w_mant    = w_carry ? w_sum[M:1] : w_sum[M-1:0];
  assign w_exp_fin = r_exp + (w_carry ? 32'sd1 : 32'sd0);
  assign w_is_inf  = (w_exp_fin > EMAX);
  assign w_is_zero = (w_exp_fin < EMIN);
  assign w_inexact_fin = w_guard | w_sticky | w_is_inf | w_is_zero;

  svfloat_packer #(.N(N), .E(E)) u_packer (
    .i_sign    (r_sign),
    .i_exp     (w_exp_fin),
    .i_mant    (w_mant),
    .i_is_zero (w_is_zero),
    .i_is_inf  (w_is_inf),
    .o_float   (w_packed)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_next = NORM;
        else          w_next = IDLE;
      end
      NORM: begin
        if (r_mag == {width{1'b0}}) w_next = DONE;
        else if (r_mag[width-1])    w_next = ROUND;
        else                        w_next = NORM;
      end
      ROUND: w_next = DONE;
      DONE: begin
        if (out_ready) w_next = IDLE;
        else           w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: capture, normalise one bit per cycle, then latch the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag     <= {width{1'b0}};
      r_sign    <= 1'b0;
      r_exp     <= 32'sd0;
      r_out     <= {N{1'b0}};
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_mag  <= w_mag_in;
            r_sign <= w_neg;
            r_exp  <= EXP0;
          end
        end
        NORM: begin
          if (r_mag == {width{1'b0}}) begin
            r_out     <= {N{1'b0}};
            r_inexact <= 1'b0;
          end else if (!r_mag[width-1]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - 32'sd1;
          end
        end
        ROUND: begin
          r_out     <= w_packed;
          r_inexact <= w_inexact_fin;
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out       = r_out;
  assign inexact   = r_inexact;

endmodule

// File: doc/svfloat_itof.md
SVFLOAT_ITOF -- requirements
Module: svfloat_itof

Interface
REQ-001 SHALL have parameter float, default svfloat::float32; output floating-point type.
REQ-002 SHALL have parameter width, default 32; input integer bit count.
REQ-003 SHALL have parameter frac, default 0; number of fractional bits in the input.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input word valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an input.
REQ-008 SHALL have port in  input  width  fixed-point integer to convert.
REQ-009 SHALL have port issigned  input  1  in is two's complement; sampled with in.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out  output  $bits(float)  converted floating-point value.
REQ-013 SHALL have port inexact  output  1  result differs from the exact input value; valid with out.

Function
REQ-014 SHALL use FSM states IDLE, NORM, ROUND, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, on in_valid&&in_ready, capture magnitude (negate if issigned&&in[width-1]), sign, exponent=width-1-frac, and go to NORM.
REQ-016 SHALL treat the magnitude as width-bit unsigned, so signed minimum (e.g. 0x80000000) is representable.
REQ-017 SHALL, for zero magnitude, go NORM->DONE with out=+0, inexact=0.
REQ-018 SHALL, in NORM, go to ROUND if magnitude MSB=1, else shift left 1 and decrement exponent; one bit per cycle.
REQ-019 SHALL assert out_valid exactly lz+2 rising edges after the accept edge (lz = leading zeros of magnitude); zero input: 1 edge.
REQ-020 SHALL, in ROUND, take the top mwidth bits as mantissa, compute guard/sticky from the rest, apply rounding (REQ-030/031), renormalize on mantissa carry (exponent+1), and go to DONE.
REQ-021 SHALL encode exponent field as exponent+bias, bias=2^(E-1)-1, E=$bits(exponent field).
REQ-022 SHALL produce ±infinity with inexact=1 when the final exponent exceeds the maximum normal exponent.
REQ-023 SHALL flush to ±0 with inexact=1 when the final exponent is below the minimum normal exponent; no subnormal output.
REQ-024 SHALL hold out and inexact stable in DONE while out_ready=0; go to IDLE on out_ready=1.
REQ-025 SHALL ignore in, issigned and in_valid outside IDLE.

Reset
REQ-026 SHALL, on rst_n=0, go to IDLE immediately regardless of state, discarding any in-flight conversion.
REQ-027 SHALL reset out_valid=0, in_ready=1, out=0, inexact=0, all internal registers 0.
REQ-028 SHALL accept a new input on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL use macro SVFLOAT_ITOF_ROUND_EN to select rounding.
REQ-030 SHALL, with SVFLOAT_ITOF_ROUND_EN defined, round to nearest, ties to even.
REQ-031 SHALL, without it, truncate toward zero (no mantissa carry); inexact still reports discarded nonzero bits.

Structure
REQ-032 SHALL take float typedefs (float32, float16, ...) from package svfloat; FSM state enum also lives in svfloat.
REQ-033 SHALL instantiate sub-module svfloat_packer (sign, true exponent, mantissa, is_zero, is_inf -> float).

Verification
REQ-034 SHALL cover: float32/32/0, in=1 unsigned -> out=0x3F800000, inexact=0, out_valid 33 edges after accept.
REQ-035 SHALL cover: in=0x80000000 signed -> 0xCF000000 after 2 edges; in=0xFFFFFFFF signed -> 0xBF800000.
REQ-036 SHALL cover: in=0xFFFFFFFF unsigned -> 0x4F800000 inexact=1 (ROUND_EN); 0x4F7FFFFF inexact=1 (no ROUND_EN).
REQ-037 SHALL cover: ties with ROUND_EN: in=0x01000001 -> 0x4B800000; in=0x01000003 -> 0x4B800002; both inexact=1.
REQ-038 SHALL cover: frac=16, in=0x00018000 -> 0x3FC00000; out_ready=0 for 5 cycles holds out; in_ready stays 0.
REQ-039 SHALL cover: rst_n=0 mid-NORM -> out_valid=0, in_ready=1 same cycle; next conversion correct.
